mc_control_unit: RTL
====================

# mc_control_unit

Multi-cycle MIPS control unit: a state machine that sequences each instruction through fetch, decode, execute, memory and writeback. It drives the shared-ALU/shared-memory datapath strobes and handshakes with a variable-latency memory. It flags illegal instructions and memory timeouts, and counts retired instructions. It is the sequential successor to the single-cycle combinational decoder and keeps that decoder's ALU control encoding: ADD=101, SUB=110, AND=001, OR=011, XOR=010, with SLT=111 added.

## Interface
- MEM_TIMEOUT, 16: consecutive mem_ready-low cycles tolerated in FETCH/MEM; 0 disables the timeout.
- CNT_W, 32: width of the retired-instruction counter.
- ENABLE_EXT, 1: 1 enables SLT, BNE and J; 0 decodes them as illegal.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- inst  in  32  instruction register contents; stable from DECODE onward.
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory completes the current request this cycle.
- state  out  3  FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5.
- mem_req  out  1  memory request.
- mem_we  out  1  write request; valid only with mem_req.
- iord  out  1  address select: 0=PC, 1=ALUOut.
- ir_write  out  1  load instruction register.
- pc_write  out  1  load PC.
- pc_src  out  2  PC source: 00=ALU (PC+4), 01=ALUOut (branch target), 10=jump target.
- alu_src_a  out  1  ALU A input: 0=PC, 1=rs.
- alu_src_b  out  2  ALU B input: 00=rt, 01=constant 4, 10=sign-extended imm, 11=sign-extended imm<<2.
- alu_control  out  3  ALU operation, encoding as above.
- reg_dst  out  1  write register: 1=rd, 0=rt.
- mem_to_reg  out  1  writeback source: 1=memory data, 0=ALUOut.
- reg_write  out  1  register file write.
- retired  out  1  one-cycle pulse when an instruction completes.
- instret  out  CNT_W  retired-instruction count.
- illegal  out  1  sticky flag: illegal instruction.
- timeout  out  1  sticky flag: memory timeout.

## Operation
- Supported instructions: R-type (funct ADD 100000, SUB 100010, AND 100100, OR 100101, XOR 100110, SLT 101010), LW 100011, SW 101011, ADDI 001000, BEQ 000100, BNE 000101, J 000010.
- All strobes default to 0. alu_control defaults to ADD.
- FETCH
  - Drives mem_req=1, iord=0, alu_src_a=0, alu_src_b=01, ADD.
  - In the cycle mem_ready=1: ir_write=1, pc_write=1, pc_src=00; next state DECODE.
- DECODE
  - Drives alu_src_a=0, alu_src_b=11, ADD, so ALUOut holds the branch target.
  - Unsupported opcode or funct (including ENABLE_EXT-gated instructions when ENABLE_EXT=0): next state TRAP, illegal set.
  - J: pc_write=1, pc_src=10, retired=1; next state FETCH.
  - Otherwise: next state EXEC.
- EXEC
  - R-type: alu_src_a=1, alu_src_b=00, alu_control from funct; next state WB.
  - LW, SW, ADDI: alu_src_a=1, alu_src_b=10, ADD. LW and SW go to MEM; ADDI goes to WB.
  - BEQ, BNE: alu_src_a=1, alu_src_b=00, SUB, pc_src=01. pc_write=zero for BEQ, pc_write=!zero for BNE. retired=1; next state FETCH.
- MEM
  - Drives mem_req=1, iord=1, mem_we=1 for SW.
  - On mem_ready: SW pulses retired=1 and goes to FETCH; LW goes to WB.
- WB
  - reg_write=1; reg_dst=1 for R-type, 0 otherwise; mem_to_reg=1 for LW.
  - retired=1; next state FETCH.
- TRAP
  - All strobes 0. State held until reset. illegal and timeout stay sticky.
- Wait counter (MEM_TIMEOUT>0)
  - Cleared on entry to FETCH or MEM; increments each cycle mem_ready=0 in those states.
  - If mem_ready stays 0 for MEM_TIMEOUT consecutive cycles, the next state is TRAP and timeout is set.
  - mem_ready=1 in the would-be timeout cycle completes normally; ready wins.
- instret increments on every retired pulse and wraps modulo 2^CNT_W.

## Timing
- Reset: rst_n low at a clock edge sets state=FETCH, instret=0, illegal=0, timeout=0 and clears the wait counter.
  - While rst_n is low, all combinational strobes are forced to 0, including mem_req.
  - Reset mid-instruction abandons the instruction with no retired pulse.
- Strobes are combinational from state and inst. Mealy terms: ir_write and pc_write in FETCH, mem completion in MEM (mem_ready), and the branch pc_write (zero).
- Cycles per instruction with zero wait states:
  - J: 2
  - BEQ, BNE: 3
  - R-type, ADDI, SW: 4
  - LW: 5
  - Each memory wait cycle adds 1.
- retired is asserted in the final cycle of the instruction; instret shows the new value on the following cycle.

## Test plan
- Reset, then ADD (000000…100000) with mem_ready always 1: states 0,1,2,4; reg_write=1 and reg_dst=1 in cycle 4; instret=1.
- LW with 3 wait cycles in FETCH and 2 in MEM: 10 cycles total; mem_to_reg=1 and reg_write=1 in WB; iord=1 during MEM.
- BEQ with zero=1: pc_write=1 and pc_src=01 in EXEC. BNE with zero=1: pc_write=0. Both retire in 3 cycles.
- Opcode 111111: DECODE goes to TRAP; illegal=1; all strobes 0 for 20 further cycles; rst_n=0 clears illegal.
- MEM_TIMEOUT=16, mem_ready held 0 in FETCH: state=TRAP after 16 cycles and timeout=1. Repeat with mem_ready=1 exactly in cycle 16: normal entry to DECODE.
- ENABLE_EXT=0 with J or SLT: goes to TRAP with illegal=1. CNT_W=4: 16 retirements wrap instret to 0.

Source files
------------

// File: rtl/mc_control_unit.sv
// mc_control_unit: multi-cycle MIPS control FSM with variable-latency memory handshake, trap flags and retire counter
module mc_control_unit #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W = 32,
    parameter bit ENABLE_EXT = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      inst,
    input  logic             zero,
    input  logic             mem_ready,
    output logic [2:0]       state,
    output logic             mem_req,
    output logic             mem_we,
    output logic             iord,
    output logic             ir_write,
    output logic             pc_write,
    output logic [1:0]       pc_src,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [2:0]       alu_control,
    output logic             reg_dst,
    output logic             mem_to_reg,
    output logic             reg_write,
    output logic             retired,
    output logic [CNT_W-1:0] instret,
    output logic             illegal,
    output logic             timeout
);
    typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, TRAP} state_t;
    localparam logic [2:0] ALU_ADD = 3'b101;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam int WC_W = MEM_TIMEOUT > 1 ? $clog2(MEM_TIMEOUT) : 1;
    state_t cur, nxt;
    logic [WC_W-1:0] wait_cnt;
    logic [2:0] r_alu;
    logic r_ok, is_r, is_lw, is_sw, is_addi, is_beq, is_bne, is_j;
    logic legal, waiting, expired, unused_fields;
    assign state = cur;
    assign is_r = inst[31:26] == 6'b000000;
    assign is_lw = inst[31:26] == 6'b100011;
    assign is_sw = inst[31:26] == 6'b101011;
    assign is_addi = inst[31:26] == 6'b001000;
    assign is_beq = inst[31:26] == 6'b000100;
    assign is_bne = ENABLE_EXT && inst[31:26] == 6'b000101;
    assign is_j = ENABLE_EXT && inst[31:26] == 6'b000010;
    assign legal = (is_r && r_ok) || is_lw || is_sw || is_addi || is_beq || is_bne || is_j;
    assign unused_fields = ^inst[25:6];
    // The would-be timeout cycle still completes if mem_ready arrives in it.
    assign waiting = cur == FETCH || cur == MEM;
    assign expired = MEM_TIMEOUT != 0 && waiting && !mem_ready && wait_cnt == WC_W'(MEM_TIMEOUT - 1);
    always_comb begin
        r_alu = ALU_ADD;
        r_ok = 1'b1;
        case (inst[5:0])
            6'b100000: r_alu = ALU_ADD;
            6'b100010: r_alu = ALU_SUB;
            6'b100100: r_alu = 3'b001;
            6'b100101: r_alu = 3'b011;
            6'b100110: r_alu = 3'b010;
            6'b101010: begin
                r_alu = 3'b111;
                r_ok = ENABLE_EXT;
            end
            default: r_ok = 1'b0;
        endcase
    end
    always_comb begin
        nxt = cur;
        mem_req = 1'b0;
        mem_we = 1'b0;
        iord = 1'b0;
        ir_write = 1'b0;
        pc_write = 1'b0;
        pc_src = 2'b00;
        alu_src_a = 1'b0;
        alu_src_b = 2'b00;
        alu_control = ALU_ADD;
        reg_dst = 1'b0;
        mem_to_reg = 1'b0;
        reg_write = 1'b0;
        retired = 1'b0;
        if (rst_n) begin
            case (cur)
                FETCH: begin
                    mem_req = 1'b1;
                    alu_src_b = 2'b01;
                    ir_write = mem_ready;
                    pc_write = mem_ready;
                    nxt = mem_ready ? DECODE : expired ? TRAP : FETCH;
                end
                DECODE: begin
                    alu_src_b = 2'b11;
                    pc_write = is_j;
                    pc_src = is_j ? 2'b10 : 2'b00;
                    retired = is_j;
                    nxt = !legal ? TRAP : is_j ? FETCH : EXEC;
                end
                EXEC: begin
                    alu_src_a = 1'b1;
                    if (is_r) begin
                        alu_control = r_alu;
                        nxt = WB;
                    end else if (is_beq || is_bne) begin
                        alu_control = ALU_SUB;
                        pc_src = 2'b01;
                        pc_write = is_beq ? zero : !zero;
                        retired = 1'b1;
                        nxt = FETCH;
                    end else begin
                        alu_src_b = 2'b10;
                        nxt = is_addi ? WB : MEM;
                    end
                end
                MEM: begin
                    mem_req = 1'b1;
                    iord = 1'b1;
                    mem_we = is_sw;
                    retired = mem_ready && is_sw;
                    nxt = mem_ready ? (is_sw ? FETCH : WB) : expired ? TRAP : MEM;
                end
                WB: begin
                    reg_write = 1'b1;
                    reg_dst = is_r;
                    mem_to_reg = is_lw;
                    retired = 1'b1;
                    nxt = FETCH;
                end
                default: nxt = TRAP;
            endcase
        end
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cur <= FETCH;
            wait_cnt <= '0;
            instret <= '0;
            illegal <= 1'b0;
            timeout <= 1'b0;
        end else begin
            cur <= nxt;
            wait_cnt <= (waiting && !mem_ready && !expired) ? wait_cnt + WC_W'(1) : '0;
            if (retired) instret <= instret + CNT_W'(1);
            if (cur == DECODE && !legal) illegal <= 1'b1;
            if (expired) timeout <= 1'b1;
        end
    end
endmodule
